// File: rtl/data_mem_access_unit_pkg.sv
// Shared memory-op encodings, FSM state type and beat helpers for the data memory access unit.
package data_mem_access_unit_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'b000,
    OP_WORD   = 3'b001,
    OP_BYTE   = 3'b010,
    OP_HALF   = 3'b011,
    OP_BYTE_U = 3'b100,
    OP_HALF_U = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  // Number of byte beats; 0 marks an op that is undecoded for the given direction.
  function automatic logic [2:0] beat_count(input logic [2:0] op, input logic is_write);
    logic [2:0] n;
    case (op)
      OP_WORD:   n = 3'd4;
      OP_BYTE:   n = 3'd1;
      OP_HALF:   n = 3'd2;
      OP_BYTE_U: n = is_write ? 3'd0 : 3'd1;
      OP_HALF_U: n = is_write ? 3'd0 : 3'd2;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    return ((op == OP_WORD) && (addr_lo != 2'b00)) ||
           (((op == OP_HALF) || (op == OP_HALF_U)) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/data_mem_access_unit_if.sv
// Pipeline-side and byte-wide memory-side signals of the data memory access unit.
interface data_mem_access_unit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              stall;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;
  logic [7:0]        mem_rdata;

  modport slave (
    input  mem_read, mem_write, mem_op, addr, wdata, mem_ready, mem_rdata,
    output stall, rdata, done, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_op, addr, wdata, mem_ready, mem_rdata,
    input  stall, rdata, done, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_access_unit_mem_load_extend.sv
// Turns the assembled little-endian load word into the sign/zero-extended register value.
module mem_load_extend
  import data_mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  mem_op_e     op_i,
  output logic [31:0] rdata_c_o
);

  always_comb begin
    case (op_i)
      OP_WORD:   rdata_c_o = word_i;
      OP_BYTE:   rdata_c_o = {{24{word_i[7]}}, word_i[7:0]};
      OP_HALF:   rdata_c_o = {{16{word_i[15]}}, word_i[15:0]};
      OP_BYTE_U: rdata_c_o = {24'h0, word_i[7:0]};
      OP_HALF_U: rdata_c_o = {16'h0, word_i[15:0]};
      default:   rdata_c_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store engine over a byte-wide memory port, stalling the pipeline per access.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses abort with err.
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  data_mem_access_unit_if.slave  bus
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  mem_op_e           op_q, op_d;
  logic              write_q, write_d;
  logic [2:0]        beats_q, beats_d;
  logic [2:0]        beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;

  logic              start_c;
  logic              accept_c;
  logic              misalign_c;
  logic [2:0]        n_c;
  logic [WAIT_W-1:0] wait_inc_c;
  logic [31:0]       asm_next_c;
  logic [31:0]       ext_c;

  assign start_c    = (state_q == ST_IDLE) && (bus.mem_read || bus.mem_write);
  assign accept_c   = req_q && bus.mem_ready;
  assign n_c        = beat_count(bus.mem_op, bus.mem_write);
  assign wait_inc_c = wait_q + WAIT_W'(1);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_c = is_misaligned(bus.mem_op, bus.addr[1:0]);
`else
  assign misalign_c = 1'b0;
`endif

  // Byte assembly including the byte arriving this cycle, so the final value is ready at DONE.
  always_comb begin
    asm_next_c = asm_q;
    if (accept_c) asm_next_c[{beat_q[1:0], 3'b000} +: 8] = bus.mem_rdata;
  end

  mem_load_extend u_extend (
    .word_i    (asm_next_c),
    .op_i      (op_q),
    .rdata_c_o (ext_c)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    write_d = write_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_next_c;
    rdata_d = 32'h0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          op_d    = mem_op_e'(bus.mem_op);
          write_d = bus.mem_write;
          beats_d = n_c;
          beat_d  = 3'd0;
          wait_d  = '0;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          asm_d   = 32'h0;
          if ((n_c == 3'd0) || misalign_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = (n_c != 3'd0);
          end else begin
            state_d = ST_ACCESS;
            req_d   = 1'b1;
            we_d    = bus.mem_write;
          end
        end
      end
      ST_ACCESS: begin
        if (accept_c) begin
          wait_d = '0;
          if (beat_q == beats_q - 3'd1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            req_d   = 1'b0;
            we_d    = 1'b0;
            rdata_d = write_q ? 32'h0 : ext_c;
          end else begin
            beat_d  = beat_q + 3'd1;
            addr_d  = addr_q + ADDR_W'(1);
            wdata_d = {8'h0, wdata_q[31:8]};
          end
        end else if ((MAX_WAIT != 0) && (wait_inc_c == WAIT_W'(MAX_WAIT))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          wait_d = wait_inc_c;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      write_q <= 1'b0;
      beats_q <= 3'd0;
      beat_q  <= 3'd0;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      write_q <= write_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  // stall must rise in the request cycle itself, hence the combinational start term.
  assign bus.stall     = start_c || (state_q == ST_ACCESS);
  assign bus.rdata     = rdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q[7:0];

endmodule
